tl_ul_sram_responder: RTL and testbench

- TileLink-UL responder (manager end) for the A/D channel bundle that our TL-UL adapters pass through toward slaves.
- Accepts Get, PutFullData and PutPartialData on channel A against a local word-addressed SRAM and returns AccessAckData or AccessAck on channel D.
- Registered single-stage response path: full throughput with backpressure; illegal requests are answered with denied, never dropped.
- Sits at the leaf of the peripheral crossbar as a scratchpad or test target.

---
 rtl/tl_ul_pkg.sv | 43 ++++
 rtl/tl_ul_sram_responder_if.sv | 40 ++++
 rtl/tl_ul_byte_ram.sv | 34 +++
 rtl/tl_ul_sram_responder.sv | 131 +++++++++++++
 tb/tb_tl_ul_sram_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions: opcodes, channel structs and the byte-lane helper.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // A-channel request fields (source kept outside so its width can vary).
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_chan_t;

  // Registered D-channel response fields; read marks a legal Get whose
  // data comes from the RAM read register.
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic       denied;
    logic       corrupt;
    logic       read;
  } d_chan_t;

  // Byte lanes covered by an aligned access of 2^size bytes at addr_lo.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
    logic [3:0] lanes;
    case (size)
      2'd0:    lanes = 4'b0001 << addr_lo;
      2'd1:    lanes = 4'b0011 << {addr_lo[1], 1'b0};
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/tl_ul_sram_responder_if.sv
// TL-UL A/D channel bundle; master drives requests, slave answers.
interface tl_ul_if #(
  parameter int SOURCE_W = 4
);
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [1:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [31:0]         a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;
  logic                a_corrupt;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [1:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_sink;
  logic                d_denied;
  logic [31:0]         d_data;
  logic                d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_byte_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and registered read.
module tl_ul_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One independent byte-wide memory per lane keeps the byte enables trivial.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    // Either a masked write or a read per cycle; read register holds otherwise.
    always_ff @(posedge clock) begin
      if (en) begin
        if (we) begin
          if (be[gi]) mem[addr] <= wdata[gi*8 +: 8];
        end else begin
          rdata_reg <= mem[addr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = rdata_reg;
  end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TL-UL manager endpoint: legality check, one-deep D register, error counter.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DEPTH     = 256,
  parameter int          SOURCE_W  = 4,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_ul_if.slave               bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  a_chan_t             a_req;
  d_chan_t             d_next;
  d_chan_t             d_reg;
  logic [SOURCE_W-1:0] d_source_reg;
  logic                d_valid_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic        fire;
  logic        denied;
  logic [31:0] offset;
  logic [3:0]  lanes;
  logic        in_range;
  logic        aligned;
  logic        opcode_ok;
  logic        mask_ok;
  logic        full_ok;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        unused_bits;

  assign a_req = '{opcode:  bus.a_opcode,
                   param:   bus.a_param,
                   size:    bus.a_size,
                   address: bus.a_address,
                   mask:    bus.a_mask,
                   data:    bus.a_data,
                   corrupt: bus.a_corrupt};

  // Poisoned write data is still written; poison is not tracked.
  assign unused_bits = ^{a_req.corrupt, offset[31:AW+2], offset[1:0]};

  assign bus.a_ready = !d_valid_reg || bus.d_ready;
  assign fire        = bus.a_valid && bus.a_ready;
  assign offset      = a_req.address - BASE_ADDR;
  assign lanes       = lane_mask(a_req.address[1:0], a_req.size);

  // Legality of the presented request and the response it would produce.
  always_comb begin
    opcode_ok = (a_req.opcode == PUT_FULL) || (a_req.opcode == PUT_PARTIAL) ||
                (a_req.opcode == GET);
    in_range  = (a_req.address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    case (a_req.size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !a_req.address[0];
      2'd2:    aligned = (a_req.address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    mask_ok = ((a_req.mask & ~lanes) == 4'b0000);
    full_ok = (a_req.opcode != PUT_FULL) || (a_req.mask == lanes);
    denied  = !(opcode_ok && (a_req.param == 3'd0) && aligned && in_range &&
                mask_ok && full_ok);

    d_next         = '0;
    d_next.opcode  = ((a_req.opcode == PUT_FULL) || (a_req.opcode == PUT_PARTIAL))
                     ? ACCESS_ACK : ACCESS_ACK_DATA;
    d_next.size    = a_req.size;
    d_next.denied  = denied;
    d_next.corrupt = denied && (d_next.opcode == ACCESS_ACK_DATA);
    d_next.read    = !denied && (a_req.opcode == GET);
  end

  assign ram_en = fire && !denied;
  assign ram_we = (a_req.opcode != GET);

  tl_ul_byte_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .be    (a_req.mask),
    .addr  (offset[AW+1:2]),
    .wdata (a_req.data),
    .rdata (ram_rdata)
  );

  // D register: load on fire, drop only when drained without a new fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_reg  <= 1'b0;
      d_reg        <= '0;
      d_source_reg <= '0;
    end else if (fire) begin
      d_valid_reg  <= 1'b1;
      d_reg        <= d_next;
      d_source_reg <= bus.a_source;
    end else if (bus.d_ready) begin
      d_valid_reg  <= 1'b0;
    end
  end

  // Saturating count of denied requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count_reg <= '0;
    end else if (fire && denied && (err_count_reg != {ERR_CNT_W{1'b1}})) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign err_count     = err_count_reg;
  assign bus.d_valid   = d_valid_reg;
  assign bus.d_opcode  = d_reg.opcode;
  assign bus.d_param   = 2'b00;
  assign bus.d_size    = d_reg.size;
  assign bus.d_source  = d_source_reg;
  assign bus.d_sink    = 1'b0;
  assign bus.d_denied  = d_reg.denied;
  assign bus.d_corrupt = d_reg.corrupt;
  assign bus.d_data    = d_reg.read ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Scoreboard bench for tl_ul_sram_responder: directed cases plus random traffic.
module tb_tl_ul_sram_responder;
  import tl_ul_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 256;
  localparam int          SW    = 4;
  localparam int          EW    = 8;
  localparam int          EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [EW-1:0] err_count;

  tl_ul_if #(.SOURCE_W(SW)) bus ();

  tl_ul_sram_responder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .SOURCE_W  (SW),
    .ERR_CNT_W (EW)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic          denied;
    logic [31:0]   data;
    logic          corrupt;
    int            errc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  int          ref_err = 0;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          dr_mode = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply the legality rules directly on byte addresses.
  function automatic exp_t model(input logic [2:0] op, input logic [2:0] param,
                                 input logic [1:0] size, input logic [SW-1:0] src,
                                 input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data);
    exp_t   e;
    int     nbytes;
    int     lo;
    int     covered;
    int     idx;
    longint a;
    bit     legal;
    nbytes  = 1 << size;
    lo      = int'(addr % 4);
    covered = (((1 << nbytes) - 1) << lo) & 15;
    a       = longint'(addr);
    legal   = (op == 0 || op == 1 || op == 4) && (param == 0) && (size <= 2) &&
              ((addr % nbytes) == 0) && (a >= longint'(BASE)) &&
              (a < longint'(BASE) + 4 * DEPTH) &&
              ((int'(mask) & ~covered) == 0) && (op != 0 || int'(mask) == covered);
    e.src     = src;
    e.size    = size;
    e.denied  = !legal;
    e.op      = (op == 0 || op == 1) ? 3'd0 : 3'd1;
    e.data    = 32'h0;
    e.corrupt = 1'b0;
    if (!legal) begin
      e.corrupt = (e.op == 3'd1);
      if (ref_err < EMAX) ref_err = ref_err + 1;
    end else begin
      idx = int'((a - longint'(BASE)) / 4);
      if (op == 4) e.data = ref_mem[idx];
      else
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
    e.errc = ref_err;
    return e;
  endfunction

  function automatic logic [63:0] dfields();
    return 64'({bus.d_opcode, bus.d_param, bus.d_size, bus.d_source, bus.d_sink,
                bus.d_denied, bus.d_corrupt, bus.d_data});
  endfunction

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // d_ready driver: 0 low, 1 high, otherwise random backpressure.
  initial begin
    bus.d_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (dr_mode)
        0:       bus.d_ready = 1'b0;
        1:       bus.d_ready = 1'b1;
        default: bus.d_ready = (($urandom % 4) != 0);
      endcase
    end
  end

  // Monitor: pop and compare on every D handshake; check hold while stalled.
  initial begin
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [63:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_d_valid", 64'(bus.d_valid), 64'd1);
          chk("hold_d_fields", dfields(), held);
        end
        if (bus.d_valid && bus.d_ready) begin
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: got response src %0d, expected none", bus.d_source);
          end else begin
            e = sb.pop_front();
            chk("d_opcode", 64'(bus.d_opcode), 64'(e.op));
            chk("d_size", 64'(bus.d_size), 64'(e.size));
            chk("d_source", 64'(bus.d_source), 64'(e.src));
            chk("d_denied", 64'(bus.d_denied), 64'(e.denied));
            chk("d_data", 64'(bus.d_data), 64'(e.data));
            chk("d_corrupt", 64'(bus.d_corrupt), 64'(e.corrupt));
            chk("d_param_sink", 64'({bus.d_param, bus.d_sink}), 64'd0);
            chk("err_count", 64'(err_count), 64'(e.errc));
            $display("resp src=%0d op=%0d den=%0d data=%08h err=%0d",
                     bus.d_source, bus.d_opcode, bus.d_denied, bus.d_data, err_count);
            last_pop_cyc = cyc;
          end
        end
        stall_prev = bus.d_valid && !bus.d_ready;
        held       = dfields();
      end
    end
  end

  // Present one request, wait for acceptance, record expectation.
  task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                      input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [SW-1:0] src);
    int n = 0;
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = param;
    bus.a_size    = size;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_source  = src;
    bus.a_corrupt = 1'($urandom % 2);
    forever begin
      @(negedge clk);
      if (bus.a_ready) break;
      n++;
      if (n >= 200) begin
        checks++;
        fails++;
        $display("FAIL a_ready_timeout: got a_ready=0 for 200 cycles, expected 1");
        bus.a_valid = 1'b0;
        return;
      end
    end
    sb.push_back(model(op, param, size, src, addr, mask, data));
    $display("req op=%0d size=%0d addr=%08h mask=%h data=%08h src=%0d",
             op, size, addr, mask, data, src);
    @(posedge clk);
    #1;
    chk("latency_d_valid", 64'(bus.d_valid), 64'd1);
    bus.a_valid = 1'b0;
  endtask

  task automatic set_ready(input int mode);
    @(negedge clk);
    dr_mode = mode;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    set_ready(1);
    while ((sb.size() != 0 || bus.d_valid) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    int start;
    bus.a_valid   = 1'b0;
    bus.a_opcode  = '0;
    bus.a_param   = '0;
    bus.a_size    = '0;
    bus.a_source  = '0;
    bus.a_address = '0;
    bus.a_mask    = '0;
    bus.a_data    = '0;
    bus.a_corrupt = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst_d_fields", dfields(), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd1);

    // Fill every word so the model knows the whole SRAM.
    for (int w = 0; w < DEPTH; w++)
      send(PUT_FULL, 3'd0, 2'd2, BASE + 32'(4 * w), 4'hF, $urandom, 4'(w));

    // Put then Get; byte write over the same word.
    send(PUT_FULL, 3'd0, 2'd2, 32'h2000_0010, 4'hF, 32'hDEADBEEF, 4'd3);
    send(GET,      3'd0, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 4'd5);
    send(PUT_PARTIAL, 3'd0, 2'd0, 32'h2000_0011, 4'h2, 32'h0000AA00, 4'd6);
    send(GET,      3'd0, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 4'd7);
    drain();
    chk("ram_partial_word", 64'(ref_mem[4]), 64'h0000_0000_DEADAAEF);

    // Out-of-range and misaligned Gets are denied.
    send(GET, 3'd0, 2'd2, 32'h2000_0400, 4'hF, 32'h0, 4'd1);
    send(GET, 3'd0, 2'd2, 32'h2000_0002, 4'hF, 32'h0, 4'd2);
    drain();
    chk("err_after_denied", 64'(err_count), 64'd2);
    send(GET, 3'd0, 2'd2, 32'h2000_0000, 4'hF, 32'h0, 4'd4);
    drain();

    // Backpressure: held response, blocked request, then no-bubble restart.
    set_ready(0);
    send(GET, 3'd0, 2'd2, 32'h2000_0010, 4'hF, 32'h0, 4'd1);
    fork
      send(GET, 3'd0, 2'd2, 32'h2000_0014, 4'hF, 32'h0, 4'd2);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_a_ready", 64'(bus.a_ready), 64'd0);
        end
        dr_mode = 1;
      end
    join
    drain();

    // Throughput: 8 back-to-back Gets finish in 9 cycles.
    start = cyc;
    for (int i = 0; i < 8; i++)
      send(GET, 3'd0, 2'd2, BASE + 32'(4 * i), 4'hF, 32'h0, 4'(i));
    drain();
    chk("b2b_cycles", 64'(last_pop_cyc + 1 - start), 64'd9);

    // Random traffic under random backpressure.
    set_ready(2);
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [2:0]  param;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  mask;
      int          r;
      int          off;
      int          lanes;
      r     = int'($urandom % 16);
      op    = (r < 5) ? PUT_FULL : (r < 10) ? PUT_PARTIAL : (r < 15) ? GET : 3'($urandom_range(2, 7));
      param = (($urandom % 20) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      size  = (($urandom % 20) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off   = int'($urandom % 4);
      if (($urandom % 10) != 0) off = off & ~((1 << size) - 1);
      addr  = BASE + 32'(4 * ($urandom % DEPTH)) + 32'(off);
      if (($urandom % 25) == 0) addr = BASE + 32'(4 * DEPTH) + ($urandom % 64);
      if (($urandom % 50) == 0) addr = BASE - 32'd4;
      lanes = (((1 << (1 << size)) - 1) << (off % 4)) & 15;
      mask  = (op == PUT_FULL) ? 4'(lanes) : 4'(lanes & int'($urandom));
      if (($urandom % 15) == 0) mask = 4'($urandom);
      send(op, param, size, addr, mask, $urandom, 4'($urandom));
    end
    drain();

    // Illegal opcode and short PutFull mask, then saturation.
    send(3'd2,     3'd0, 2'd2, 32'h2000_0020, 4'hF, 32'h0, 4'd8);
    send(PUT_FULL, 3'd0, 2'd2, 32'h2000_0020, 4'h3, 32'h1234, 4'd9);
    for (int i = 0; i < 300; i++)
      send(GET, 3'd0, 2'd2, 32'h2000_0400 + 32'(4 * i), 4'hF, 32'h0, 4'(i));
    drain();
    chk("err_saturated", 64'(err_count), 64'(EMAX));
    send(GET, 3'd0, 2'd2, 32'h2000_0020, 4'hF, 32'h0, 4'd10);
    drain();

    // Reset with a stalled response pending; written data survives.
    set_ready(0);
    send(PUT_FULL, 3'd0, 2'd2, 32'h2000_0040, 4'hF, 32'h1234_5678, 4'd9);
    #1;
    rst = 1'b1;
    sb.delete();
    ref_err = 0;
    @(posedge clk);
    #1;
    chk("midrst_d_valid", 64'(bus.d_valid), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    chk("midrst_a_ready", 64'(bus.a_ready), 64'd1);
    #1;
    rst = 1'b0;
    set_ready(1);
    send(GET, 3'd0, 2'd2, 32'h2000_0040, 4'hF, 32'h0, 4'd10);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
